// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, drives a start bit, shifts out
// data plus odd parity on device clock falls, then checks the device acknowledge.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] send_data,
    input  logic       send_valid,
    output logic       send_ready,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_BITS      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                 clk_prev_q;
    logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [8:0]           shift_q, shift_d;
    logic                 ack_ok_q, ack_ok_d;
    logic                 clock_oe_q, clock_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 ready_q, ready_d;

    logic clk_s, data_s, fall_s, accept_s, in_xfer_s, timeout_s, bus_idle_s;

    // Bus idles high, so synchronizers reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clock_in};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign fall_s     = clk_prev_q & ~clk_s;
    assign bus_idle_s = clk_s & data_s;
    assign accept_s   = send_valid & ready_q;
    assign in_xfer_s  = (state_q == S_BITS) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign timeout_s  = in_xfer_s && (tmo_cnt_q == TMO_LAST);

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            inh_cnt_q  <= {INH_W{1'b0}};
            tmo_cnt_q  <= {TMO_W{1'b0}};
            bit_cnt_q  <= 4'd0;
            shift_q    <= 9'd0;
            ack_ok_q   <= 1'b0;
            clock_oe_q <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_ok_q   <= ack_ok_d;
            clock_oe_q <= clock_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state and datapath updates; timeout outranks any simultaneous fall.
    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ack_ok_d  = ack_ok_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d   = S_INHIBIT;
                    inh_cnt_d = {INH_W{1'b0}};
                    shift_d   = {~^send_data, send_data};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d   = S_START;
                    inh_cnt_d = {INH_W{1'b0}};
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_START: begin
                state_d   = S_BITS;
                bit_cnt_d = 4'd0;
                tmo_cnt_d = {TMO_W{1'b0}};
            end
            S_BITS, S_ACK, S_WAIT_IDLE: begin
                if (timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (state_q == S_BITS) begin
                        if (fall_s && (bit_cnt_q == 4'd9)) begin
                            state_d = S_ACK;
                        end else if (fall_s) begin
                            shift_d   = {1'b0, shift_q[8:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            state_d = S_BITS;
                        end
                    end else if (state_q == S_ACK) begin
                        if (fall_s) begin
                            ack_ok_d = ~data_s;
                            state_d  = S_WAIT_IDLE;
                        end else begin
                            state_d = S_ACK;
                        end
                    end else begin
                        if (bus_idle_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values; data only moves in the cycle after a detected fall.
    always_comb begin
        clock_oe_d = (state_d == S_INHIBIT) || (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
        if (state_d == S_IDLE) begin
            data_oe_d = 1'b0;
        end else if (state_d == S_START) begin
            data_oe_d = 1'b1;
        end else if ((state_q == S_BITS) && fall_s) begin
            data_oe_d = (bit_cnt_q == 4'd9) ? 1'b0 : ~shift_q[0];
        end else begin
            data_oe_d = data_oe_q;
        end
        if ((state_q == S_WAIT_IDLE) && !timeout_s && bus_idle_s) begin
            done_d  = ack_ok_q;
            error_d = ~ack_ok_q;
        end else begin
            done_d  = 1'b0;
            error_d = timeout_s;
        end
        ready_d = (state_d == S_IDLE) && !done_d && !error_d;
    end

    assign ps2_clock_oe = clock_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign tx_error     = error_q;
    assign send_ready   = ready_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a simple PS/2 device model
// clocking at a 40-cycle period.
module tb_ps2_host_transmitter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] send_data = 8'h00;
    logic       send_valid = 1'b0;
    logic       send_ready;
    logic       ps2_clock_in, ps2_data_in;
    logic       ps2_clock_oe, ps2_data_oe;
    logic       tx_busy, tx_done, tx_error;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic scramble     = 1'b0;
    logic prev_pulse   = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n_done = 0;
    int   n_err = 0;
    int   n_acc = 0;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(10),
        .TIMEOUT_CYCLES(2000),
        .SYNC_STAGES   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .send_data   (send_data),
        .send_valid  (send_valid),
        .send_ready  (send_ready),
        .ps2_clock_in(ps2_clock_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    // Open-drain bus: either side can pull a line low.
    assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (prev_pulse) check("ready_after_pulse", {31'd0, send_ready}, 32'd1);
        if (tx_done || tx_error) begin
            check("ready_in_pulse", {31'd0, send_ready}, 32'd0);
            check("pulse_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
        end
        if (tx_done) n_done++;
        if (tx_error) n_err++;
        prev_pulse = tx_done | tx_error;
    end

    always @(posedge clock) begin
        if (!reset && send_valid && send_ready) n_acc++;
    end

    task automatic tick();
        @(negedge clock);
        if (scramble) begin
            if (tx_done || tx_error) begin
                send_valid = 1'b0;
                scramble   = 1'b0;
            end else begin
                send_data = send_data + 8'h11;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic hold);
        int n = 0;
        while (!send_ready && n < 5000) begin
            tick();
            n++;
        end
        check("ready_before_send", {31'd0, send_ready}, 32'd1);
        send_data  = b;
        send_valid = 1'b1;
        tick();
        if (!hold) send_valid = 1'b0;
        check("busy_after_accept", {30'd0, tx_busy, send_ready}, 32'd2);
    endtask

    task automatic measure_inhibit();
        int n_inh = 0;
        int n_ovl = 0;
        while (ps2_clock_oe && !ps2_data_oe && n_inh < 100) begin
            n_inh++;
            tick();
        end
        while (ps2_clock_oe && ps2_data_oe && n_ovl < 100) begin
            n_ovl++;
            tick();
        end
        check("inhibit_cycles", n_inh, 32'd10);
        check("start_overlap", n_ovl, 32'd1);
        check("released_start_bit", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd1);
    endtask

    task automatic dev_xfer(input logic ack, output logic [10:0] frame);
        frame = 11'd0;
        for (int i = 0; i < 11; i++) begin
            for (int t = 0; t < 20; t++) begin
                if (t == 10) frame[i] = ps2_data_in;
                if (i == 10 && t == 15 && ack) dev_data_low = 1'b1;
                tick();
            end
            dev_clk_low = 1'b1;
            repeat (20) tick();
            dev_clk_low = 1'b0;
        end
        repeat (5) tick();
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!send_ready && n < 5000) begin
            tick();
            n++;
        end
        check("idle_reached", {31'd0, send_ready}, 32'd1);
        repeat (2) tick();
    endtask

    task automatic xfer(input logic [7:0] b, input logic par, input logic ack, input logic hold);
        int d0 = n_done;
        int e0 = n_err;
        logic [10:0] fr;
        send(b, hold);
        if (hold) scramble = 1'b1;
        measure_inhibit();
        dev_xfer(ack, fr);
        check("frame", {21'd0, fr}, {21'd0, 1'b1, par, b, 1'b0});
        wait_idle();
        check("done_count", n_done - d0, ack ? 32'd1 : 32'd0);
        check("error_count", n_err - e0, ack ? 32'd0 : 32'd1);
        check("lines_released", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int e0;
        int a0;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {26'd0, send_ready, ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 32'h20);
        reset = 1'b0;
        tick();
        check("post_reset_outputs", {26'd0, send_ready, ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 32'h20);

        // 1: 0xED with ack, parity 1
        xfer(8'hED, 1'b1, 1'b1, 1'b0);

        // 2: 0x01 (parity 0) then 0xFF (parity 1)
        a0 = n_acc;
        xfer(8'h01, 1'b0, 1'b1, 1'b0);
        xfer(8'hFF, 1'b1, 1'b1, 1'b0);
        check("accepts_two", n_acc - a0, 32'd2);

        // 3: device leaves data high at the ack fall
        xfer(8'hAA, 1'b1, 1'b0, 1'b0);

        // 4: device never clocks
        d0 = n_done;
        e0 = n_err;
        send(8'h55, 1'b0);
        measure_inhibit();
        n = 0;
        while (!tx_error && n < 3000) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 32'd2000);
        check("timeout_lines", {29'd0, ps2_clock_oe, ps2_data_oe, tx_busy}, 32'd0);
        wait_idle();
        check("timeout_err_count", n_err - e0, 32'd1);
        check("timeout_done_count", n_done - d0, 32'd0);

        // 5: reset after the 4th data bit, then a normal 0xF4
        d0 = n_done;
        e0 = n_err;
        send(8'h96, 1'b0);
        measure_inhibit();
        for (int i = 0; i < 4; i++) begin
            repeat (20) tick();
            dev_clk_low = 1'b1;
            repeat (20) tick();
            dev_clk_low = 1'b0;
        end
        repeat (20) tick();
        check("mid_xfer_busy", {30'd0, tx_busy, ps2_clock_oe}, 32'd2);
        reset = 1'b1;
        tick();
        check("mid_reset_outputs", {26'd0, send_ready, ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 32'h20);
        reset = 1'b0;
        repeat (10) tick();
        check("mid_reset_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);
        check("mid_reset_idle", {30'd0, tx_busy, send_ready}, 32'd1);
        xfer(8'hF4, 1'b0, 1'b1, 1'b0);

        // 6: send_valid held with changing data while busy
        a0 = n_acc;
        xfer(8'h3C, 1'b1, 1'b1, 1'b1);
        check("single_accept", n_acc - a0, 32'd1);
        repeat (5) tick();
        check("no_extra_transfer", {30'd0, tx_busy, ps2_clock_oe}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
